// File: rtl/poca_master.sv
// POCA top-level sequencer: drives TRNG, ECC and hash engines over a shared
// address/handshake bus to build the authenticity response and shared secret.
//
// state        | meaning
// IDLE         | wait for go
// TRNG_WRITE   | request private key a from TRNG
// TRNG_READ    | collect a
// ECC_WRITE    | start Qa = a*G
// TRNG_WRITE_P | request nonce P from TRNG
// TRNG_READ_P  | collect P
// HASH_WRITE   | start H(R)
// HASH_READ    | collect H(R)
// ECC_READ     | collect Qa
// HASH_WRITE_1 | start H(G,P,Qa,R)
// HASH_READ_1  | collect H2
// OUTPUT_POCA  | publish response, wait for HSM key Qh
// ECC_WRITE_SK | start shared secret a*Qh
// ECC_READ_SK  | drain shared secret burst
// DONE         | secret ready, wait for go low
module poca_master #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int GEN_W     = 256,
  parameter int RESP_W    = 256,
  parameter int KEY_W     = 128,
  parameter int ECC_OUT_W = 256,
  parameter int HASH_W    = 256,
  parameter int ECC_IN_W  = 256,
  parameter int KS_W      = 8,
  parameter int EN_W      = 4,
  parameter logic [ADDR_W-1:0] TRNG_BASE = 'h0100,
  parameter logic [ADDR_W-1:0] ECC_BASE  = 'h0200,
  parameter logic [ADDR_W-1:0] HASH_BASE = 'h0300
) (
  input  logic                                       clk,
  input  logic                                       rstn,
  input  logic                                       go,
  input  logic [GEN_W-1:0]                           generator_mult,
  input  logic [RESP_W-1:0]                          test_response,
  input  logic [KS_W-1:0]                            KS_value,
  input  logic                                       write_complete,
  input  logic [DATA_W-1:0]                          data_in,
  input  logic                                       data_input_ready,
  input  logic                                       input_data_transfer_complete,
  input  logic                                       hsm_key_received,
  input  logic [ECC_OUT_W-1:0]                       hsm_public_key,
  output logic                                       capture_cntl,
  output logic [2*HASH_W+ECC_OUT_W-1:0]              poca_output_response,
  output logic [ADDR_W-1:0]                          addr_out,
  output logic                                       is_write,
  output logic [EN_W-1:0]                            enable_data_out,
  output logic [ECC_IN_W-1:0]                        ecc_input_1,
  output logic [ECC_IN_W-1:0]                        ecc_input_2,
  output logic [RESP_W-1:0]                          hash_input_r,
  output logic [GEN_W+KEY_W+ECC_OUT_W+RESP_W-1:0]    hash_input_g_p_qa_r,
  output logic                                       shared_secret_key_ready,
  output logic                                       poca_output_ready
);

  typedef enum logic [3:0] {
    IDLE, TRNG_WRITE, TRNG_READ, ECC_WRITE, TRNG_WRITE_P, TRNG_READ_P,
    HASH_WRITE, HASH_READ, ECC_READ, HASH_WRITE_1, HASH_READ_1,
    OUTPUT_POCA, ECC_WRITE_SK, ECC_READ_SK, DONE
  } state_t;

  localparam int BUS_W = ADDR_W + 1 + EN_W;
  localparam logic [ADDR_W-1:0] RD_OFS = 'h10;
  localparam logic [EN_W-1:0] EN_TRNG = EN_W'(1);
  localparam logic [EN_W-1:0] EN_ECC  = EN_W'(2);
  localparam logic [EN_W-1:0] EN_HASH = EN_W'(4);

  state_t                  state;
  logic [KS_W-1:0]         ks_reg;
  logic [KEY_W-1:0]        key_a, p_reg;
  logic [HASH_W-1:0]       hash_r, hash_2;
  logic [ECC_OUT_W-1:0]    qa;

  logic [KEY_W-1:0]        key_a_cap, p_cap;
  logic [HASH_W-1:0]       hash_r_cap, hash_2_cap;
  logic [ECC_OUT_W-1:0]    qa_cap;

  // Bus settings {addr, is_write, enable} presented while in state s.
  function automatic logic [BUS_W-1:0] bus_cfg(input state_t s, input logic [KS_W-1:0] ks);
    logic [ADDR_W-1:0] a;
    logic              w;
    logic [EN_W-1:0]   e;
    a = '0;
    w = 1'b0;
    e = '0;
    case (s)
      TRNG_WRITE, TRNG_WRITE_P: begin a = TRNG_BASE + ADDR_W'(ks); w = 1'b1; e = EN_TRNG; end
      TRNG_READ, TRNG_READ_P:   begin a = TRNG_BASE + RD_OFS;               e = EN_TRNG; end
      ECC_WRITE, ECC_WRITE_SK:  begin a = ECC_BASE;              w = 1'b1; e = EN_ECC;  end
      ECC_READ, ECC_READ_SK:    begin a = ECC_BASE + RD_OFS;                e = EN_ECC;  end
      HASH_WRITE, HASH_WRITE_1: begin a = HASH_BASE;             w = 1'b1; e = EN_HASH; end
      HASH_READ, HASH_READ_1:   begin a = HASH_BASE + RD_OFS;               e = EN_HASH; end
      default: ;
    endcase
    return {a, w, e};
  endfunction

  // Value each result register takes this cycle if a read word arrives; the
  // completing cycle forwards these so a coincident last word is not lost.
  always_comb begin
    key_a_cap  = key_a;
    p_cap      = p_reg;
    hash_r_cap = hash_r;
    hash_2_cap = hash_2;
    qa_cap     = qa;
    if (data_input_ready) begin
      key_a_cap  = {key_a[KEY_W-DATA_W-1:0], data_in};
      p_cap      = {p_reg[KEY_W-DATA_W-1:0], data_in};
      hash_r_cap = {hash_r[HASH_W-DATA_W-1:0], data_in};
      hash_2_cap = {hash_2[HASH_W-DATA_W-1:0], data_in};
      qa_cap     = {qa[ECC_OUT_W-DATA_W-1:0], data_in};
    end
  end

  // Sequencer with registered bus, operand and status outputs.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state                   <= IDLE;
      ks_reg                  <= '0;
      key_a                   <= '0;
      p_reg                   <= '0;
      hash_r                  <= '0;
      hash_2                  <= '0;
      qa                      <= '0;
      capture_cntl            <= 1'b0;
      poca_output_response    <= '0;
      addr_out                <= '0;
      is_write                <= 1'b0;
      enable_data_out         <= '0;
      ecc_input_1             <= '0;
      ecc_input_2             <= '0;
      hash_input_r            <= '0;
      hash_input_g_p_qa_r     <= '0;
      shared_secret_key_ready <= 1'b0;
      poca_output_ready       <= 1'b0;
    end else begin
      capture_cntl <= 1'b0;
      case (state)
        IDLE: if (go) begin
          ks_reg       <= KS_value;
          capture_cntl <= 1'b1;
          state        <= TRNG_WRITE;
          {addr_out, is_write, enable_data_out} <= bus_cfg(TRNG_WRITE, KS_value);
        end
        TRNG_WRITE: if (write_complete) begin
          key_a <= '0;
          state <= TRNG_READ;
          {addr_out, is_write, enable_data_out} <= bus_cfg(TRNG_READ, ks_reg);
        end
        TRNG_READ: begin
          key_a <= key_a_cap;
          if (input_data_transfer_complete) begin
            ecc_input_1 <= ECC_IN_W'(generator_mult);
            ecc_input_2 <= ECC_IN_W'(key_a_cap);
            state       <= ECC_WRITE;
            {addr_out, is_write, enable_data_out} <= bus_cfg(ECC_WRITE, ks_reg);
          end
        end
        ECC_WRITE: if (write_complete) begin
          state <= TRNG_WRITE_P;
          {addr_out, is_write, enable_data_out} <= bus_cfg(TRNG_WRITE_P, ks_reg);
        end
        TRNG_WRITE_P: if (write_complete) begin
          p_reg <= '0;
          state <= TRNG_READ_P;
          {addr_out, is_write, enable_data_out} <= bus_cfg(TRNG_READ_P, ks_reg);
        end
        TRNG_READ_P: begin
          p_reg <= p_cap;
          if (input_data_transfer_complete) begin
            hash_input_r <= test_response;
            state        <= HASH_WRITE;
            {addr_out, is_write, enable_data_out} <= bus_cfg(HASH_WRITE, ks_reg);
          end
        end
        HASH_WRITE: if (write_complete) begin
          hash_r <= '0;
          state  <= HASH_READ;
          {addr_out, is_write, enable_data_out} <= bus_cfg(HASH_READ, ks_reg);
        end
        HASH_READ: begin
          hash_r <= hash_r_cap;
          if (input_data_transfer_complete) begin
            qa    <= '0;
            state <= ECC_READ;
            {addr_out, is_write, enable_data_out} <= bus_cfg(ECC_READ, ks_reg);
          end
        end
        ECC_READ: begin
          qa <= qa_cap;
          if (input_data_transfer_complete) begin
            hash_input_g_p_qa_r <= {generator_mult, p_reg, qa_cap, hash_input_r};
            state               <= HASH_WRITE_1;
            {addr_out, is_write, enable_data_out} <= bus_cfg(HASH_WRITE_1, ks_reg);
          end
        end
        HASH_WRITE_1: if (write_complete) begin
          hash_2 <= '0;
          state  <= HASH_READ_1;
          {addr_out, is_write, enable_data_out} <= bus_cfg(HASH_READ_1, ks_reg);
        end
        HASH_READ_1: begin
          hash_2 <= hash_2_cap;
          if (input_data_transfer_complete) begin
            poca_output_response <= {hash_r, hash_2_cap, qa};
            poca_output_ready    <= 1'b1;
            state                <= OUTPUT_POCA;
            {addr_out, is_write, enable_data_out} <= bus_cfg(OUTPUT_POCA, ks_reg);
          end
        end
        // ecc_input_1 doubles as the latch for the HSM public key.
        OUTPUT_POCA: if (hsm_key_received) begin
          ecc_input_1 <= ECC_IN_W'(hsm_public_key);
          ecc_input_2 <= ECC_IN_W'(key_a);
          state       <= ECC_WRITE_SK;
          {addr_out, is_write, enable_data_out} <= bus_cfg(ECC_WRITE_SK, ks_reg);
        end
        ECC_WRITE_SK: if (write_complete) begin
          state <= ECC_READ_SK;
          {addr_out, is_write, enable_data_out} <= bus_cfg(ECC_READ_SK, ks_reg);
        end
        // No port carries the shared secret; only burst completion matters here.
        ECC_READ_SK: if (input_data_transfer_complete) begin
          shared_secret_key_ready <= 1'b1;
          state                   <= DONE;
          {addr_out, is_write, enable_data_out} <= bus_cfg(DONE, ks_reg);
        end
        DONE: if (!go) begin
          shared_secret_key_ready <= 1'b0;
          poca_output_ready       <= 1'b0;
          state                   <= IDLE;
          {addr_out, is_write, enable_data_out} <= bus_cfg(IDLE, ks_reg);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poca_master.sv
// Directed bench for poca_master: full sequencing flow, read-burst edge
// cases and asynchronous reset in the middle of a hash read.
module tb_poca_master;

  logic         clk = 1'b0;
  logic         rstn;
  logic         go;
  logic [255:0] generator_mult;
  logic [255:0] test_response;
  logic [7:0]   KS_value;
  logic         write_complete;
  logic [31:0]  data_in;
  logic         data_input_ready;
  logic         input_data_transfer_complete;
  logic         hsm_key_received;
  logic [255:0] hsm_public_key;
  logic         capture_cntl;
  logic [767:0] poca_output_response;
  logic [15:0]  addr_out;
  logic         is_write;
  logic [3:0]   enable_data_out;
  logic [255:0] ecc_input_1;
  logic [255:0] ecc_input_2;
  logic [255:0] hash_input_r;
  logic [895:0] hash_input_g_p_qa_r;
  logic         shared_secret_key_ready;
  logic         poca_output_ready;

  int errors = 0;
  int checks = 0;
  logic [31:0] burst [$];

  localparam logic [255:0] G_VAL  = 256'h12345678;
  localparam logic [255:0] R_VAL  = 256'h12345678;
  localparam logic [127:0] A_VAL  = 128'h00000015_00000000_00000015_00000001;
  localparam logic [127:0] P_VAL  = 128'h00000000_0000000A_0000000B_0000000C;
  localparam logic [255:0] HR_VAL = 256'h0000001F_00000001_00000015_00000005_00000005_00000005_00000005_00000005;
  localparam logic [255:0] QA_VAL = 256'h00000000_00000001_00000002_00000003_00000004_00000005_00000006_00000007;
  localparam logic [255:0] H2_VAL = 256'h00000101_00000102_00000103_00000104_00000105_00000106_00000107_00000108;

  poca_master dut (
    .clk                          (clk),
    .rstn                         (rstn),
    .go                           (go),
    .generator_mult               (generator_mult),
    .test_response                (test_response),
    .KS_value                     (KS_value),
    .write_complete               (write_complete),
    .data_in                      (data_in),
    .data_input_ready             (data_input_ready),
    .input_data_transfer_complete (input_data_transfer_complete),
    .hsm_key_received             (hsm_key_received),
    .hsm_public_key               (hsm_public_key),
    .capture_cntl                 (capture_cntl),
    .poca_output_response         (poca_output_response),
    .addr_out                     (addr_out),
    .is_write                     (is_write),
    .enable_data_out              (enable_data_out),
    .ecc_input_1                  (ecc_input_1),
    .ecc_input_2                  (ecc_input_2),
    .hash_input_r                 (hash_input_r),
    .hash_input_g_p_qa_r          (hash_input_g_p_qa_r),
    .shared_secret_key_ready      (shared_secret_key_ready),
    .poca_output_ready            (poca_output_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ack();
    write_complete = 1'b1;
    tick();
    write_complete = 1'b0;
  endtask

  // Streams the words in 'burst'; merge puts the completion on the last word.
  task automatic read_burst(input bit merge);
    for (int i = 0; i < burst.size(); i++) begin
      data_in = burst[i];
      data_input_ready = 1'b1;
      input_data_transfer_complete = merge && (i == burst.size() - 1);
      tick();
    end
    data_input_ready = 1'b0;
    input_data_transfer_complete = 1'b0;
    if (!merge) begin
      input_data_transfer_complete = 1'b1;
      tick();
      input_data_transfer_complete = 1'b0;
    end
  endtask

  task automatic chk_bus(input string tag, input logic [15:0] a, input logic w, input logic [3:0] e);
    chk({tag, "_addr"}, 256'(addr_out), 256'(a));
    chk({tag, "_wr"}, 256'(is_write), 256'(w));
    chk({tag, "_en"}, 256'(enable_data_out), 256'(e));
  endtask

  initial begin
    rstn = 1'b1;
    go = 1'b0;
    generator_mult = G_VAL;
    test_response = R_VAL;
    KS_value = 8'd5;
    write_complete = 1'b0;
    data_in = '0;
    data_input_ready = 1'b0;
    input_data_transfer_complete = 1'b0;
    hsm_key_received = 1'b0;
    hsm_public_key = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    tick();
    chk_bus("rst", 16'h0, 1'b0, 4'h0);
    chk("rst_cap", 256'(capture_cntl), 256'd0);
    chk("rst_rdy", 256'(poca_output_ready), 256'd0);
    chk("rst_ss", 256'(shared_secret_key_ready), 256'd0);
    chk("rst_e1", ecc_input_1, 256'd0);

    // start
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("go_cap", 256'(capture_cntl), 256'd1);
    chk_bus("trng_w", 16'h0105, 1'b1, 4'b0001);
    tick();
    chk("cap_pulse", 256'(capture_cntl), 256'd0);
    chk("trng_w_hold", 256'(addr_out), 256'h0105);
    write_ack();
    chk_bus("trng_r", 16'h0110, 1'b0, 4'b0001);

    burst = '{32'h15, 32'h0, 32'h15, 32'h1};
    read_burst(1'b0);
    chk_bus("ecc_w", 16'h0200, 1'b1, 4'b0010);
    chk("ecc_in2_a", ecc_input_2, 256'(A_VAL));
    chk("ecc_in1_g", ecc_input_1, G_VAL);

    write_ack();
    chk_bus("trng_wp", 16'h0105, 1'b1, 4'b0001);
    write_ack();
    chk_bus("trng_rp", 16'h0110, 1'b0, 4'b0001);
    burst = '{32'hA, 32'hB, 32'hC};
    read_burst(1'b0);
    chk_bus("hash_w", 16'h0300, 1'b1, 4'b0100);
    chk("hash_in_r", hash_input_r, R_VAL);

    write_ack();
    chk_bus("hash_r", 16'h0310, 1'b0, 4'b0100);
    burst = '{32'h1F, 32'h1, 32'h15, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5};
    read_burst(1'b1);
    chk_bus("ecc_r", 16'h0210, 1'b0, 4'b0010);
    burst = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
    read_burst(1'b0);
    chk_bus("hash_w1", 16'h0300, 1'b1, 4'b0100);
    chk("gpqr_g", hash_input_g_p_qa_r[895:640], G_VAL);
    chk("gpqr_p", 256'(hash_input_g_p_qa_r[639:512]), 256'(P_VAL));
    chk("gpqr_qa", hash_input_g_p_qa_r[511:256], QA_VAL);
    chk("gpqr_r", hash_input_g_p_qa_r[255:0], R_VAL);

    write_ack();
    chk_bus("hash_r1", 16'h0310, 1'b0, 4'b0100);
    burst = '{32'hDEAD, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107, 32'h108};
    read_burst(1'b0);
    chk("out_rdy", 256'(poca_output_ready), 256'd1);
    chk("out_hr", poca_output_response[767:512], HR_VAL);
    chk("out_h2", poca_output_response[511:256], H2_VAL);
    chk("out_qa", poca_output_response[255:0], QA_VAL);
    chk_bus("out_bus", 16'h0, 1'b0, 4'h0);
    tick();
    chk("out_wait_rdy", 256'(poca_output_ready), 256'd1);

    hsm_public_key = 256'h12345678;
    hsm_key_received = 1'b1;
    tick();
    hsm_key_received = 1'b0;
    hsm_public_key = '0;
    chk_bus("ecc_wsk", 16'h0200, 1'b1, 4'b0010);
    chk("sk_in1", ecc_input_1, 256'h12345678);
    chk("sk_in2", ecc_input_2, 256'(A_VAL));
    write_ack();
    chk_bus("ecc_rsk", 16'h0210, 1'b0, 4'b0010);
    go = 1'b1;
    burst = '{32'h55, 32'h66};
    read_burst(1'b1);
    chk("ss_rdy", 256'(shared_secret_key_ready), 256'd1);
    chk("done_out_rdy", 256'(poca_output_ready), 256'd1);
    tick();
    chk("done_hold", 256'(shared_secret_key_ready), 256'd1);
    go = 1'b0;
    tick();
    chk("idle_ss", 256'(shared_secret_key_ready), 256'd0);
    chk("idle_rdy", 256'(poca_output_ready), 256'd0);
    chk("idle_cap", 256'(capture_cntl), 256'd0);

    // second run, reset in HASH_READ
    KS_value = 8'd2;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("go2_cap", 256'(capture_cntl), 256'd1);
    chk("go2_addr", 256'(addr_out), 256'h0102);
    write_ack();
    burst = '{32'h9, 32'h8, 32'h7, 32'h6};
    read_burst(1'b1);
    chk("run2_a", ecc_input_2, 256'h00000009_00000008_00000007_00000006);
    write_ack();
    chk("run2_wp_addr", 256'(addr_out), 256'h0102);
    write_ack();
    burst = '{32'h1};
    read_burst(1'b1);
    write_ack();
    chk_bus("run2_hash_r", 16'h0310, 1'b0, 4'b0100);
    data_in = 32'h77;
    data_input_ready = 1'b1;
    tick();
    data_input_ready = 1'b0;
    #2 rstn = 1'b1;
    #1;
    chk_bus("mid_rst", 16'h0, 1'b0, 4'h0);
    chk("mid_rst_e1", ecc_input_1, 256'd0);
    chk("mid_rst_e2", ecc_input_2, 256'd0);
    chk("mid_rst_hr", hash_input_r, 256'd0);
    chk("mid_rst_resp", poca_output_response[255:0], 256'd0);
    #2 rstn = 1'b0;
    tick();
    chk_bus("post_rst", 16'h0, 1'b0, 4'h0);
    KS_value = 8'd3;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("post_rst_cap", 256'(capture_cntl), 256'd1);
    chk("post_rst_addr", 256'(addr_out), 256'h0103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
